// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: port count plus output-arbiter types and defaults.
package xbar_pkg;

    localparam int ports        = 4;
    localparam int ARB_SEL_W    = $clog2(ports);
    localparam int ARB_MAX_HOLD = 80;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first set req bit searching upward from ptr+1,
// wrapping modulo NUM_REQ. Shared by the output arbiters and the input-side scheduler.
module rr_priority_sel
    import xbar_pkg::*;
#(
    parameter int NUM_REQ = ports,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(i);
            if (sum >= (SEL_W+1)'(NUM_REQ))
                sum = sum - (SEL_W+1)'(NUM_REQ);
            idx = sum[SEL_W-1:0];
            if (req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_out_arbiter.sv
// Per-output-port round-robin arbiter; grants only on slot_tick and holds for a packet.
// Optional forced release after MAX_HOLD cycles when XBAR_ARB_TIMEOUT_EN is defined.
module xbar_out_arbiter
    import xbar_pkg::*;
#(
    parameter int NUM_REQ  = ports,
    parameter int SEL_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slot_tick,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] valid,
    input  logic [NUM_REQ-1:0] eop,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [SEL_W-1:0]   mux_sel,
    output logic               timeout_err
);

    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("xbar_out_arbiter: MAX_HOLD must be at least 2");
    end

    arb_state_t         state_q, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic [SEL_W-1:0]   ptr_q, ptr_n;
    logic [SEL_W-1:0]   win;
    logic               found;
    logic               rel;
    logic               tmo_hit;

    rr_priority_sel #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_sel (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win),
        .found  (found)
    );

    // mux_sel holds the current winner for the whole packet.
    assign rel       = (valid[mux_sel] & eop[mux_sel]) | ~req[mux_sel];
    assign gnt_valid = |gnt;

    always_comb begin
        state_n = state_q;
        gnt_n   = gnt;
        sel_n   = mux_sel;
        ptr_n   = ptr_q;
        case (state_q)
            IDLE: begin
                if (slot_tick && found) begin
                    state_n    = HOLD;
                    gnt_n      = '0;
                    gnt_n[win] = 1'b1;
                    sel_n      = win;
                end
            end
            HOLD: begin
                // Release beats a coincident slot_tick: no grant until the next tick.
                if (rel || tmo_hit) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = mux_sel;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            mux_sel <= '0;
            ptr_q   <= SEL_W'(NUM_REQ-1);
        end else begin
            state_q <= state_n;
            gnt     <= gnt_n;
            mux_sel <= sel_n;
            ptr_q   <= ptr_n;
        end
    end

`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt;
    logic             tmo_err_q;

    assign tmo_hit     = (state_q == HOLD) && (hold_cnt == CNT_W'(MAX_HOLD-1));
    assign timeout_err = tmo_err_q;

    // Counter sits at zero in IDLE, so every HOLD entry starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt  <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            hold_cnt  <= (state_q == HOLD) ? hold_cnt + 1'b1 : '0;
            tmo_err_q <= tmo_hit & ~rel;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_xbar_out_arbiter.sv
// Directed bench for xbar_out_arbiter: vector table plus reset and timeout sequences.
module tb_xbar_out_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       slot_tick;
    logic [3:0] req, valid, eop;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] mux_sel;
    logic       timeout_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    xbar_out_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .slot_tick   (slot_tick),
        .req         (req),
        .valid       (valid),
        .eop         (eop),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .mux_sel     (mux_sel),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic       tick;
        logic [3:0] req;
        logic [3:0] valid;
        logic [3:0] eop;
        logic [3:0] gnt;
        logic       gv;
        logic [1:0] sel;
    } vec_t;

    vec_t vt[30];

    function automatic vec_t mk(logic t, logic [3:0] r, logic [3:0] v, logic [3:0] e,
                                logic [3:0] g, logic gv, logic [1:0] s);
        vec_t x;
        x.tick = t; x.req = r; x.valid = v; x.eop = e;
        x.gnt = g; x.gv = gv; x.sel = s;
        return x;
    endfunction

    task automatic chk(string name, logic [3:0] g, logic gv, logic [1:0] s, logic t);
        total++;
        if (gnt === g && gnt_valid === gv && mux_sel === s && timeout_err === t)
            passed++;
        else
            $display("FAIL %s: got gnt=%b gv=%b sel=%0d tmo=%b, want gnt=%b gv=%b sel=%0d tmo=%b",
                     name, gnt, gnt_valid, mux_sel, timeout_err, g, gv, s, t);
    endtask

    task automatic chk_int(string name, int got, int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(logic t, logic [3:0] r, logic [3:0] v, logic [3:0] e);
        slot_tick = t; req = r; valid = v; eop = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int drop, pulses, tmo_at;

        rst = 1'b0; slot_tick = 1'b0; req = '0; valid = '0; eop = '0;
        repeat (3) @(negedge clk);
        chk("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst = 1'b1;

        // Requests without a tick never grant.
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 4'b1111, 4'b0000, 4'b0000);
            chk($sformatf("no_tick_%0d", i), 4'b0000, 1'b0, 2'd0, 1'b0);
        end

        // rotation
        vt[0]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0);
        vt[1]  = mk(0, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0);
        vt[2]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1);
        vt[3]  = mk(0, 4'b1111, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1);
        vt[4]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2);
        vt[5]  = mk(0, 4'b1111, 4'b0100, 4'b0100, 4'b0000, 0, 2'd2);
        vt[6]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3);
        vt[7]  = mk(0, 4'b1111, 4'b1000, 4'b1000, 4'b0000, 0, 2'd3);
        vt[8]  = mk(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0);
        vt[9]  = mk(0, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0);
        vt[10] = mk(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        vt[11] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        // skip and wrap
        vt[12] = mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2);
        vt[13] = mk(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 0, 2'd2);
        vt[14] = mk(1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0);
        vt[15] = mk(0, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0);
        vt[16] = mk(1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1);
        // multi-beat hold on input 1; other requests, stray ticks and foreign eops ignored
        vt[17] = mk(0, 4'b1011, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1);
        vt[18] = mk(1, 4'b1011, 4'b0000, 4'b0010, 4'b0010, 1, 2'd1);
        vt[19] = mk(0, 4'b1011, 4'b1011, 4'b1001, 4'b0010, 1, 2'd1);
        vt[20] = mk(0, 4'b1011, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1);
        vt[21] = mk(0, 4'b1011, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1);
        // collision: eop with tick releases, no grant until the next tick
        vt[22] = mk(1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1);
        vt[23] = mk(1, 4'b1011, 4'b0010, 4'b0010, 4'b0000, 0, 2'd1);
        vt[24] = mk(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1);
        vt[25] = mk(1, 4'b1001, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3);
        // abort
        vt[26] = mk(0, 4'b1001, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3);
        vt[27] = mk(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 2'd3);
        vt[28] = mk(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0);
        vt[29] = mk(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0);

        for (int i = 0; i < 30; i++) begin
            step(vt[i].tick, vt[i].req, vt[i].valid, vt[i].eop);
            chk($sformatf("vec_%0d", i), vt[i].gnt, vt[i].gv, vt[i].sel, 1'b0);
        end

        // Reset mid-HOLD clears asynchronously and restores ptr so input 0 wins next.
        step(1'b1, 4'b1111, 4'b0000, 4'b0000);
        chk("pre_reset_gnt", 4'b0010, 1'b1, 2'd1, 1'b0);
        #2 rst = 1'b0;
        #1 chk("async_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 4'b1111, 4'b0000, 4'b0000);
        chk("post_reset_gnt", 4'b0001, 1'b1, 2'd0, 1'b0);
        step(1'b0, 4'b1111, 4'b0001, 4'b0001);
        chk("post_reset_rel", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Long hold with no eop.
        step(1'b1, 4'b1111, 4'b0000, 4'b0000);
        chk("long_gnt", 4'b0010, 1'b1, 2'd1, 1'b0);
        drop = -1; pulses = 0; tmo_at = -1;
        for (int k = 1; k <= 250; k++) begin
            step(1'b0, 4'b1111, 4'b0000, 4'b0000);
            if (gnt === 4'b0000 && drop < 0) drop = k;
            if (timeout_err === 1'b1) begin
                pulses++;
                tmo_at = k;
            end
            if (drop > 0 && k >= drop + 3) break;
        end
`ifdef XBAR_ARB_TIMEOUT_EN
        chk_int("timeout_drop_cycle", drop, 80);
        chk_int("timeout_pulses", pulses, 1);
        chk_int("timeout_pulse_cycle", tmo_at, 80);

        // Normal release on the limit cycle wins, no error pulse.
        step(1'b1, 4'b1111, 4'b0000, 4'b0000);
        chk("prec_gnt", 4'b0100, 1'b1, 2'd2, 1'b0);
        pulses = 0; drop = -1;
        for (int k = 1; k <= 79; k++) begin
            step(1'b0, 4'b1111, 4'b0000, 4'b0000);
            if (gnt !== 4'b0100 && drop < 0) drop = k;
            if (timeout_err === 1'b1) pulses++;
        end
        chk_int("prec_early_drop", drop, -1);
        step(1'b0, 4'b1111, 4'b0100, 4'b0100);
        chk("prec_release", 4'b0000, 1'b0, 2'd2, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, 4'b0000);
        chk("prec_after", 4'b0000, 1'b0, 2'd2, 1'b0);
        chk_int("prec_pulses", pulses, 0);
`else
        chk_int("hold_no_drop", drop, -1);
        chk_int("hold_no_pulse", pulses, 0);
        step(1'b0, 4'b1101, 4'b0000, 4'b0000);
        chk("hold_abort", 4'b0000, 1'b0, 2'd1, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
